// File: rtl/speed_uart_rx_pkg.sv
// rtl/speed_uart_rx_pkg.sv - shared constants and FSM encoding for the speed word UART receiver
package speed_uart_rx_pkg;

  localparam int DEF_DATA_SIZE = 14;
  localparam int DEF_SYS_FREQ  = 50000000;
  localparam int DEF_BAUD_RATE = 11500;
  localparam int DEF_SAMPLE    = 16;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;

endpackage

// File: rtl/speed_uart_rx_tick.sv
// rtl/speed_uart_rx_tick.sv - free-running oversample tick generator
module uart_rx_tick #(
  parameter int BAUD_DVSR = 271
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int CNT_W = (BAUD_DVSR > 1) ? $clog2(BAUD_DVSR) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DVSR - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Terminal count raises tick for one clk and wraps the counter
  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // Divider counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/speed_uart_rx.sv
// rtl/speed_uart_rx.sv - oversampling UART receiver with even parity, framing and overrun flags
module speed_uart_rx
  import speed_uart_rx_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int SYS_FREQ  = DEF_SYS_FREQ,
  parameter int BAUD_RATE = DEF_BAUD_RATE,
  parameter int SAMPLE    = DEF_SAMPLE,
  parameter int BAUD_DVSR = SYS_FREQ / (SAMPLE * BAUD_RATE)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 serial_data_in,
  input  logic                 rx_ready,
  output logic [DATA_SIZE-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int SCNT_W = (SAMPLE > 2) ? $clog2(SAMPLE) : 1;
  localparam int BCNT_W = (DATA_SIZE > 2) ? $clog2(DATA_SIZE) : 1;
  localparam logic [SCNT_W-1:0] S_MID  = SCNT_W'(SAMPLE / 2 - 1);
  localparam logic [SCNT_W-1:0] S_LAST = SCNT_W'(SAMPLE - 1);
  localparam logic [BCNT_W-1:0] B_LAST = BCNT_W'(DATA_SIZE - 1);

  logic                 tick;
  logic                 rx_line;
  logic                 stop_sample;

  logic [1:0]           sync_q, sync_d;
  state_t               state_q, state_d;
  logic [SCNT_W-1:0]    s_cnt_q, s_cnt_d;
  logic [BCNT_W-1:0]    b_cnt_q, b_cnt_d;
  logic [DATA_SIZE-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [DATA_SIZE-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;

  uart_rx_tick #(.BAUD_DVSR(BAUD_DVSR)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  assign rx_line = sync_q[1];

  // Bit framing FSM plus output register update; a good word may load in the
  // same clk as a handshake, which is why the handshake clear comes first
  always_comb begin
    sync_d       = {sync_q[0], serial_data_in};
    state_d      = state_q;
    s_cnt_d      = s_cnt_q;
    b_cnt_d      = b_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = 1'b0;
    overrun_d    = overrun_q;
    stop_sample  = 1'b0;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end

    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_line) begin
            state_d = ST_START;
            s_cnt_d = '0;
          end
        end
        ST_START: begin
          if (s_cnt_q == S_MID) begin
            s_cnt_d = '0;
            b_cnt_d = '0;
            state_d = rx_line ? ST_IDLE : ST_DATA;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (s_cnt_q == S_LAST) begin
            s_cnt_d = '0;
            shift_d = {rx_line, shift_q[DATA_SIZE-1:1]};
            if (b_cnt_q == B_LAST) state_d = ST_PARITY;
            else                   b_cnt_d = b_cnt_q + 1'b1;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
        ST_PARITY: begin
          if (s_cnt_q == S_LAST) begin
            s_cnt_d = '0;
            par_d   = rx_line;
            state_d = ST_STOP;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
        ST_STOP: begin
          if (s_cnt_q == S_LAST) begin
            s_cnt_d     = '0;
            state_d     = ST_IDLE;
            stop_sample = 1'b1;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (stop_sample) begin
      if (!rx_line) begin
        frame_err_d = 1'b1;
      end else if (!rx_valid_q || rx_ready) begin
        rx_data_d    = shift_q;
        rx_valid_d   = 1'b1;
        parity_err_d = (^shift_q) ^ par_q;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // State and output registers; the synchronizer resets to the idle line level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q       <= 2'b11;
      state_q      <= ST_IDLE;
      s_cnt_q      <= '0;
      b_cnt_q      <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      s_cnt_q      <= s_cnt_d;
      b_cnt_q      <= b_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: doc/speed_uart_rx.md
SPEED_UART_RX -- requirements
Module: speed_uart_rx

Interface
REQ-001 Parameter DATA_SIZE, default 14, payload width in bits; it equals the toll speed word width.
REQ-002 Parameter SYS_FREQ, default 50000000, system clock frequency in Hz.
REQ-003 Parameter BAUD_RATE, default 11500, line bit rate in bit/s.
REQ-004 Parameter SAMPLE, default 16, oversampling ticks per bit.
REQ-005 Parameter BAUD_DVSR, default SYS_FREQ/(SAMPLE*BAUD_RATE) = 271, clk cycles per sample tick.
REQ-006 Port clk, input, 1, single system clock; all logic is on its rising edge.
REQ-007 Port reset_n, input, 1, asynchronous active-low reset.
REQ-008 Port serial_data_in, input, 1, asynchronous serial line; it idles high.
REQ-009 Port rx_ready, input, 1, consumer accepts rx_data when high together with rx_valid.
REQ-010 Port rx_data, output, DATA_SIZE, last good received word.
REQ-011 Port rx_valid, output, 1, rx_data holds an unconsumed word.
REQ-012 Port parity_err, output, 1, the word in rx_data failed the even parity check.
REQ-013 Port frame_err, output, 1, one-clk pulse when a frame has stop bit 0.
REQ-014 Port overrun, output, 1, sticky flag; a completed frame was dropped because rx_valid was still high.

Function
REQ-015 Frame format: start (0), DATA_SIZE data bits LSB first, even parity over the data bits, stop (1); the frame is DATA_SIZE+3 bits.
REQ-016 serial_data_in passes through a 2-flop synchronizer, reset to 1, before any other use.
REQ-017 The tick generator counts 0..BAUD_DVSR-1 and pulses tick for one clk at the terminal count; it free-runs from reset.
REQ-018 The FSM states are IDLE, START, DATA, PARITY and STOP.
REQ-019 IDLE -> START when the synchronized line is low at a tick; the sample counter is cleared to 0.
REQ-020 In START, at the tick where the sample count = 7 (mid-bit): line low -> DATA with the sample count cleared; line high -> IDLE (glitch rejected, no flags).
REQ-021 In DATA, at every 16th tick (sample count = 15), shift the line into the MSB of the shift register and increment the bit counter; after DATA_SIZE bits go to PARITY.
REQ-022 In PARITY, at sample count = 15, capture the parity bit and go to STOP.
REQ-023 In STOP, at sample count = 15, sample the stop bit and go to IDLE in the same clk.
REQ-024 If the stop bit is 1 and the output register is free, load rx_data, set rx_valid and set parity_err = XOR of data and parity bit, all on the clk after the stop sample.
REQ-025 If the stop bit is 0, pulse frame_err for one clk, discard the word, and leave rx_valid, rx_data and parity_err unchanged.
REQ-026 If the stop bit is 1 but rx_valid is high and rx_ready is low, drop the new word and set overrun.
REQ-027 When rx_valid && rx_ready is in the same clk as a good stop sample, the new word loads and overrun is not set.
REQ-028 The handshake rx_valid && rx_ready clears rx_valid and overrun on the next clk; rx_data and parity_err hold their values.
REQ-029 A line held low continuously produces frame_err once per frame time and never sets rx_valid.
REQ-030 Latency: the stop-bit sample tick to rx_valid high is exactly 1 clk.

Reset
REQ-031 Reset forces: state IDLE, counters 0, synchronizer 1, rx_data 0, rx_valid 0, parity_err 0, frame_err 0, overrun 0.
REQ-032 Reset asserted mid-frame aborts the frame with no flag; after release, reception resumes on the next falling edge seen in IDLE.

Structure
REQ-033 A shared package speed_uart_rx_pkg holds the FSM state encoding and the default DATA_SIZE, SYS_FREQ, BAUD_RATE and SAMPLE constants.
REQ-034 The tick generator is the sub-module uart_rx_tick, with ports clk, reset_n and tick and parameter BAUD_DVSR; all other logic stays in speed_uart_rx.

Verification
REQ-035 Send word 14'h1A5B with correct parity and stop=1, rx_ready=1 -> rx_valid pulses once, rx_data=14'h1A5B, parity_err=0, no other flags.
REQ-036 Send 14'h0001 with parity bit 0 -> rx_data=14'h0001, rx_valid=1, parity_err=1.
REQ-037 Send 14'h2AAA with stop=0 -> frame_err pulses for 1 clk, rx_valid stays 0, rx_data keeps its previous value.
REQ-038 Hold rx_ready=0 and send 14'h0100 then 14'h0200 -> rx_data=14'h0100 and overrun=1; after one handshake, rx_valid=0 and overrun=0.
REQ-039 Drive a 2000-clk low glitch in idle (shorter than a half-bit of 2168 clk) -> no flags and no rx_valid; a following frame of 14'h3FFF is received correctly.
REQ-040 Assert reset_n=0 in the middle of bit 7 of a frame -> all outputs read 0; after release, a new frame of 14'h0123 is received correctly.
